// File: rtl/pn_seq_arbiter.sv
// Round-robin owner of one shared LFSR PN generator: each grant loads the winner's
// seed/polynomial/order and streams chips to that consumer until length or abort.
module pn_seq_arbiter #(
  parameter int unsigned LEN_W = 10
) (
  input  logic        ap_clk,
  input  logic        ap_rst_n,
  input  logic        clr,
  input  logic [1:0]  seq_req,
  input  logic [1:0]  chip_req,
  output logic [1:0]  chip_ack,
  output logic        chip_data,
  output logic [1:0]  grant,
  output logic [1:0]  seq_done,
  input  logic [19:0] cfg0_seed_poly,
  input  logic [19:0] cfg1_seed_poly,
  input  logic [13:0] cfg0_order_len,
  input  logic [13:0] cfg1_order_len,
  output logic        gen_load,
  output logic [9:0]  gen_seed,
  output logic [9:0]  gen_poly,
  output logic [3:0]  gen_order,
  output logic        gen_req,
  input  logic        gen_chip
);

  typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

  state_e           state_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt_q;
  logic             idx_q;
  logic             last_q;

  logic        win;
  logic [19:0] win_sp;
  logic [13:0] win_ol;
  logic        last_chip;
  logic        abort;

  always_comb begin
    // On a tie the requester not served last wins.
    win       = (seq_req == 2'b11) ? ~last_q : seq_req[1];
    win_sp    = win ? cfg1_seed_poly : cfg0_seed_poly;
    win_ol    = win ? cfg1_order_len : cfg0_order_len;
    chip_ack  = (state_q == StRun) ? (grant & chip_req) : 2'b00;
    last_chip = (|chip_ack) && (cnt_q == len_q - LEN_W'(1));
    abort     = ~seq_req[idx_q];
    seq_done  = 2'b00;
    if (((state_q == StLoad) && (len_q == '0)) || last_chip) begin
      seq_done = grant;
    end
  end

  assign gen_req   = |chip_ack;
  assign chip_data = gen_chip;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q   <= StIdle;
      grant     <= 2'b00;
      gen_load  <= 1'b0;
      gen_seed  <= '0;
      gen_poly  <= '0;
      gen_order <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      idx_q     <= 1'b0;
      last_q    <= 1'b1;
    end else if (clr) begin
      state_q   <= StIdle;
      grant     <= 2'b00;
      gen_load  <= 1'b0;
      gen_seed  <= '0;
      gen_poly  <= '0;
      gen_order <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      idx_q     <= 1'b0;
      last_q    <= 1'b1;
    end else begin
      gen_load <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (|seq_req) begin
            state_q   <= StLoad;
            grant     <= 2'b01 << win;
            idx_q     <= win;
            gen_seed  <= win_sp[19:10];
            gen_poly  <= win_sp[9:0];
            gen_order <= win_ol[13:10];
            len_q     <= LEN_W'(win_ol[9:0]);
            gen_load  <= 1'b1;
          end
        end
        StLoad: begin
          cnt_q <= '0;
          if ((len_q == '0) || abort) begin
            state_q <= StIdle;
            grant   <= 2'b00;
            last_q  <= idx_q;
          end else begin
            state_q <= StRun;
          end
        end
        StRun: begin
          if (gen_req) begin
            cnt_q <= cnt_q + LEN_W'(1);
          end
          if (last_chip || abort) begin
            state_q <= StIdle;
            grant   <= 2'b00;
            last_q  <= idx_q;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pn_seq_arbiter.sv
// Directed bench for pn_seq_arbiter: a cycle table for tie/fairness and zero length,
// plus hand-written sequences for the m-sequence, isolation, clear, abort and async reset.
module tb_pn_seq_arbiter;

  logic        ap_clk;
  logic        ap_rst_n;
  logic        clr;
  logic [1:0]  seq_req;
  logic [1:0]  chip_req;
  logic [1:0]  chip_ack;
  logic        chip_data;
  logic [1:0]  grant;
  logic [1:0]  seq_done;
  logic [19:0] cfg0_seed_poly;
  logic [19:0] cfg1_seed_poly;
  logic [13:0] cfg0_order_len;
  logic [13:0] cfg1_order_len;
  logic        gen_load;
  logic [9:0]  gen_seed;
  logic [9:0]  gen_poly;
  logic [3:0]  gen_order;
  logic        gen_req;
  logic        gen_chip;

  int n_checks = 0;
  int n_fail   = 0;

  pn_seq_arbiter #(.LEN_W(10)) dut (
    .ap_clk         (ap_clk),
    .ap_rst_n       (ap_rst_n),
    .clr            (clr),
    .seq_req        (seq_req),
    .chip_req       (chip_req),
    .chip_ack       (chip_ack),
    .chip_data      (chip_data),
    .grant          (grant),
    .seq_done       (seq_done),
    .cfg0_seed_poly (cfg0_seed_poly),
    .cfg1_seed_poly (cfg1_seed_poly),
    .cfg0_order_len (cfg0_order_len),
    .cfg1_order_len (cfg1_order_len),
    .gen_load       (gen_load),
    .gen_seed       (gen_seed),
    .gen_poly       (gen_poly),
    .gen_order      (gen_order),
    .gen_req        (gen_req),
    .gen_chip       (gen_chip)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  // Fibonacci LFSR standing in for the shared generator: output is bit 0,
  // feedback (parity of taps) enters at bit order-1.
  logic [9:0] lfsr;
  logic [9:0] lfsr_poly;
  logic [3:0] lfsr_ord;
  logic       lfsr_fb;
  assign lfsr_fb  = ^(lfsr & lfsr_poly);
  assign gen_chip = lfsr[0];

  always @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      lfsr      <= '0;
      lfsr_poly <= '0;
      lfsr_ord  <= '0;
    end else if (gen_load) begin
      lfsr      <= gen_seed;
      lfsr_poly <= gen_poly;
      lfsr_ord  <= gen_order;
    end else if (gen_req) begin
      lfsr <= (lfsr >> 1) | ({9'b0, lfsr_fb} << (lfsr_ord - 4'd1));
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_load(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge ap_clk);
      #2;
      if (gen_load) ok = 1'b1;
    end
  endtask

  typedef struct {
    bit         rst;
    logic [1:0] sreq;
    logic [1:0] creq;
    logic [9:0] len0;
    logic [1:0] e_grant;
    logic [1:0] e_ack;
    logic [1:0] e_done;
    logic       e_load;
    logic       e_greq;
    logic [9:0] e_seed;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit rst, input logic [1:0] sreq, input logic [1:0] creq,
                     input logic [9:0] len0, input logic [1:0] g, input logic [1:0] a,
                     input logic [1:0] d, input logic l, input logic r, input logic [9:0] s);
    vec_t v;
    v.rst = rst; v.sreq = sreq; v.creq = creq; v.len0 = len0;
    v.e_grant = g; v.e_ack = a; v.e_done = d; v.e_load = l; v.e_greq = r; v.e_seed = s;
    vecs.push_back(v);
  endtask

  localparam logic [9:0] S0 = 10'h0A5;
  localparam logic [9:0] S1 = 10'h15A;

  logic [14:0] exp_chips;
  bit          ok;
  int          loads, acks, done_at, first_c, last_c;
  bit          finished;

  initial begin
    exp_chips      = 15'b001101011110001;
    ap_rst_n       = 1'b0;
    clr            = 1'b0;
    seq_req        = 2'b00;
    chip_req       = 2'b00;
    cfg0_seed_poly = {S0, 10'h009};
    cfg1_seed_poly = {S1, 10'h012};
    cfg0_order_len = {4'd4, 10'd3};
    cfg1_order_len = {4'd5, 10'd3};

    // Tie from reset, len 3 each: owners 0,1,0,1.
    add(0, 2'b11, 2'b11, 10'd3, 2'b00, 2'b00, 2'b00, 0, 0, 10'h0);
    add(0, 2'b11, 2'b11, 10'd3, 2'b01, 2'b00, 2'b00, 1, 0, S0);
    add(0, 2'b11, 2'b11, 10'd3, 2'b01, 2'b01, 2'b00, 0, 1, S0);
    add(0, 2'b11, 2'b11, 10'd3, 2'b01, 2'b01, 2'b00, 0, 1, S0);
    add(0, 2'b11, 2'b11, 10'd3, 2'b01, 2'b01, 2'b01, 0, 1, S0);
    add(0, 2'b11, 2'b11, 10'd3, 2'b00, 2'b00, 2'b00, 0, 0, S0);
    add(0, 2'b11, 2'b11, 10'd3, 2'b10, 2'b00, 2'b00, 1, 0, S1);
    add(0, 2'b11, 2'b11, 10'd3, 2'b10, 2'b10, 2'b00, 0, 1, S1);
    add(0, 2'b11, 2'b11, 10'd3, 2'b10, 2'b10, 2'b00, 0, 1, S1);
    add(0, 2'b11, 2'b11, 10'd3, 2'b10, 2'b10, 2'b10, 0, 1, S1);
    add(0, 2'b11, 2'b11, 10'd3, 2'b00, 2'b00, 2'b00, 0, 0, S1);
    add(0, 2'b11, 2'b11, 10'd3, 2'b01, 2'b00, 2'b00, 1, 0, S0);
    add(0, 2'b11, 2'b11, 10'd3, 2'b01, 2'b01, 2'b00, 0, 1, S0);
    add(0, 2'b11, 2'b11, 10'd3, 2'b01, 2'b01, 2'b00, 0, 1, S0);
    add(0, 2'b11, 2'b11, 10'd3, 2'b01, 2'b01, 2'b01, 0, 1, S0);
    add(0, 2'b11, 2'b11, 10'd3, 2'b00, 2'b00, 2'b00, 0, 0, S0);
    add(0, 2'b11, 2'b11, 10'd3, 2'b10, 2'b00, 2'b00, 1, 0, S1);
    // Reset, then zero-length request: load and done together, no acks.
    add(1, 2'b00, 2'b00, 10'd0, 2'b00, 2'b00, 2'b00, 0, 0, 10'h0);
    add(0, 2'b01, 2'b01, 10'd0, 2'b00, 2'b00, 2'b00, 0, 0, 10'h0);
    add(0, 2'b01, 2'b01, 10'd0, 2'b01, 2'b00, 2'b01, 1, 0, S0);
    add(0, 2'b00, 2'b01, 10'd0, 2'b00, 2'b00, 2'b00, 0, 0, S0);
    add(0, 2'b00, 2'b00, 10'd0, 2'b00, 2'b00, 2'b00, 0, 0, S0);

    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge ap_clk);
      ap_rst_n       = !vecs[i].rst;
      seq_req        = vecs[i].sreq;
      chip_req       = vecs[i].creq;
      cfg0_order_len = {4'd4, vecs[i].len0};
      #2;
      chk($sformatf("vec%0d", i), {46'b0, grant, chip_ack, seq_done, gen_load, gen_req, gen_seed},
          {46'b0, vecs[i].e_grant, vecs[i].e_ack, vecs[i].e_done, vecs[i].e_load,
           vecs[i].e_greq, vecs[i].e_seed});
    end

    // Single 15-chip m-sequence for consumer 0.
    cfg0_seed_poly = {10'h001, 10'h009};
    cfg0_order_len = {4'd4, 10'd15};
    seq_req  = 2'b01;
    chip_req = 2'b01;
    wait_load(ok);
    chk("single_load_seen", ok, 1);
    chk("single_cfg", {gen_seed, gen_poly, gen_order}, {10'h001, 10'h009, 4'd4});
    loads = 1; acks = 0; done_at = -1; first_c = -1; last_c = -1; finished = 0;
    for (int c = 0; c < 40 && !finished; c++) begin
      @(negedge ap_clk);
      #2;
      if (gen_load) loads++;
      if (chip_ack[0]) begin
        if (acks < 15) chk($sformatf("chip%0d", acks), chip_data, exp_chips[acks]);
        if (first_c < 0) first_c = c;
        last_c = c;
        acks++;
      end
      if (seq_done[0]) begin
        done_at  = acks;
        finished = 1;
      end
    end
    @(negedge ap_clk);
    seq_req = 2'b00;
    #2;
    chk("single_grant_after", grant, 2'b00);
    chk("single_loads", loads, 1);
    chk("single_acks", acks, 15);
    chk("single_done_at", done_at, 15);
    chk("single_consecutive", last_c - first_c, 14);

    // Isolation: 0 owns, consumer 1 pokes chip_req.
    cfg0_order_len = {4'd4, 10'd20};
    seq_req  = 2'b01;
    chip_req = 2'b00;
    wait_load(ok);
    chk("iso_load_seen", ok, 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge ap_clk);
      chip_req = 2'(i);
      #2;
      chk($sformatf("iso_ack%0d", i), chip_ack, {1'b0, chip_req[0]});
      chk($sformatf("iso_greq%0d", i), gen_req, chip_req[0]);
    end
    // Synchronous clear mid-run.
    @(negedge ap_clk);
    clr      = 1'b1;
    chip_req = 2'b11;
    @(negedge ap_clk);
    clr     = 1'b0;
    seq_req = 2'b00;
    #2;
    chk("clr_outputs", {grant, chip_ack, seq_done, gen_load, gen_req, gen_seed, gen_poly, gen_order},
        '0);

    // Length-1 sequence for 0 so that last=0 before the abort of 1.
    cfg0_order_len = {4'd4, 10'd1};
    seq_req  = 2'b01;
    chip_req = 2'b01;
    wait_load(ok);
    chk("len1_load_seen", ok, 1);
    @(negedge ap_clk);
    #2;
    chk("len1_done", {chip_ack, seq_done}, {2'b01, 2'b01});
    @(negedge ap_clk);
    seq_req = 2'b00;

    // Abort consumer 1 after 5 of 20 chips.
    cfg1_order_len = {4'd5, 10'd20};
    seq_req  = 2'b10;
    chip_req = 2'b10;
    wait_load(ok);
    chk("abort_load_seen", ok, 1);
    chk("abort_grant", grant, 2'b10);
    for (int i = 0; i < 5; i++) begin
      @(negedge ap_clk);
      #2;
      chk($sformatf("abort_run%0d", i), {chip_ack, seq_done}, {2'b10, 2'b00});
    end
    @(negedge ap_clk);
    seq_req = 2'b00;
    #2;
    chk("abort_cycle", {chip_ack, seq_done}, {2'b10, 2'b00});
    @(negedge ap_clk);
    seq_req  = 2'b11;
    chip_req = 2'b11;
    #2;
    chk("abort_grant_clear", {grant, seq_done}, 4'b0000);
    wait_load(ok);
    chk("tie_after_abort_load", ok, 1);
    chk("tie_after_abort", grant, 2'b01);

    // Async reset between edges while running.
    @(negedge ap_clk);
    #2;
    chk("pre_async_ack", chip_ack, 2'b01);
    ap_rst_n = 1'b0;
    #1;
    chk("async_outputs", {grant, chip_ack, seq_done, gen_load, gen_req, gen_seed, gen_poly, gen_order},
        '0);
    repeat (2) @(negedge ap_clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pn_seq_arbiter.md
# pn_seq_arbiter

Shares one LFSR PN-sequence generator between two chip consumers, e.g. a spreader and a despreader in the same noc_block. It arbitrates whole sequences round-robin. For each sequence it loads the winner's seed, polynomial and order into the generator, then passes the chip stream to that consumer until the programmed length is delivered or the consumer aborts. It sits between the setting registers / HLS consumers and the `pn_seq_gen_lfsr` instance.

## Interface
- `LEN_W`, 10: width of sequence length and chip counter.
- `ap_clk` in 1: single clock for all logic.
- `ap_rst_n` in 1: asynchronous, active-low reset.
- `clr` in 1: synchronous clear (block reset from setting register); same effect as reset, one cycle.
- `seq_req` in 2: level; bit i requests ownership for one full sequence.
- `chip_req` in 2: bit i pulses once per chip wanted by consumer i.
- `chip_ack` out 2: chip delivered to consumer i this cycle.
- `chip_data` out 1: current chip; valid for the granted consumer.
- `grant` out 2: one-hot (or zero) owner; registered.
- `seq_done` out 2: one-cycle pulse when owner i received its full length.
- `cfg0_seed_poly`, `cfg1_seed_poly` in 20: [19:10] seed, [9:0] polynomial.
- `cfg0_order_len`, `cfg1_order_len` in 14: [13:10] order, [9:0] length.
- `gen_load` out 1: one-cycle load strobe to generator.
- `gen_seed`, `gen_poly` out 10; `gen_order` out 4: registered generator config.
- `gen_req` out 1: advance generator one chip.
- `gen_chip` in 1: generator current output.

## Operation
- FSM states IDLE, LOAD, RUN.
- **IDLE**
  - If any `seq_req` is set, pick a winner i.
  - Round-robin: when both request, the winner is the requester not granted last. The `last` register resets to 1, so requester 0 wins the first tie.
  - Latch cfg_i into `gen_seed`/`gen_poly`/`gen_order`/`len_q` and go to LOAD.
  - `grant` goes to one-hot i at the same edge.
- **LOAD**
  - `gen_load`=1 for exactly one cycle; chip counter cleared.
  - If `len_q`==0: pulse `seq_done[i]`, drop `grant`, go to IDLE.
  - Otherwise go to RUN.
- **RUN**
  - `chip_ack[i]` = `chip_req[i]` (combinational, granted bit only); `gen_req` = `chip_ack[i]`; `chip_data` = `gen_chip`.
  - Every ack increments the counter.
  - On the ack where counter == `len_q`-1: pulse `seq_done[i]`, clear `grant`, set `last`=i, go to IDLE.
- **Abort:** if `seq_req[i]` is low in RUN or LOAD, go to IDLE next cycle. No `seq_done` pulse; `last`=i. An ack in the abort cycle is still honoured if `chip_req` is high.
- A non-granted consumer's `chip_req` is ignored and its `chip_ack` stays 0. It must hold `seq_req` until granted.
- Config changes during LOAD/RUN are ignored until the next arbitration.
- `chip_data` is driven as `gen_chip` at all times; it is meaningful only when `chip_ack` is high.

## Timing
- **Reset** (async `ap_rst_n` low, or `clr` high at a clock edge):
  - State IDLE.
  - `grant`, `chip_ack`, `seq_done`, `gen_load`, `gen_req` = 0.
  - `gen_seed`/`gen_poly`/`gen_order` = 0; counter 0; `last`=1.
  - Reset mid-RUN discards the sequence with no `seq_done`.
- **Latency:** `seq_req` high at edge n in IDLE → `grant` and `gen_load` high in cycle n+1 → RUN from cycle n+2. The first chip can be acked in cycle n+2.
- **Throughput:** one chip per cycle while `chip_req` is held high.
- **Idle gap:** at least one IDLE cycle between sequences, so re-arbitration takes 1 cycle after release.
- **Counter:** `LEN_W` bits, never wraps; max length 1023 chips.
- `seq_done` is coincident with the final `chip_ack`. `grant` is low the following cycle.

## Test plan
- Single sequence:
  - Stimulus: req0 with seed 0x001, poly 0x009, order 4, len 15; `chip_req0` held high.
  - Response: `gen_load` one cycle; 15 acks on consecutive cycles; `chip_data` matches the LFSR m-sequence; `seq_done0` on the 15th ack; `grant`=0 after.
- Tie and fairness:
  - Stimulus: both `seq_req` high from reset, len 3 each.
  - Response: grants in order 0,1,0,1, each preceded by one `gen_load` carrying that requester's config.
- Abort:
  - Stimulus: drop `seq_req1` after 5 of 20 chips.
  - Response: `grant` clears next cycle; no `seq_done1`; the next tie goes to 0.
- Zero length:
  - Stimulus: req0 with len 0.
  - Response: `gen_load` pulse and `seq_done0` in the same LOAD cycle; no acks.
- Isolation and clear:
  - Stimulus: `chip_req1` toggling while 0 owns the generator.
  - Response: `chip_ack1`=0 and `gen_req` is driven only by `chip_req0`.
  - Stimulus: `clr` mid-RUN.
  - Response: all outputs 0 next cycle.
- Async reset:
  - Stimulus: assert `ap_rst_n` low between clock edges in RUN.
  - Response: outputs 0 immediately, without waiting for an edge.
